// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 host bridge: FSM encoding, engine handshake limits,
// hash initial values and the engine-address-to-word-index mapping.
package sha256_pkg;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    DRAIN
  } bridge_state_t;

  localparam int WAIT_BUSY_LIMIT = 8;
  localparam int HASH_WORDS      = 8;

  localparam logic [31:0] SHA256_IV [HASH_WORDS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [15:0] word_index(input logic [15:0] addr, input logic [15:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/sha256_word_ram.sv
// Local word memory shared by host loader and engine: engine reads are registered (1 cycle),
// drain reads are combinational; no backpressure, out-of-range engine writes are dropped and flagged.
module sha256_word_ram
  import sha256_pkg::*;
#(
  parameter int          MEM_WORDS = 32,
  parameter logic [15:0] MSG_BASE  = 16'h0000,
  parameter int          AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          mem_we,
  input  logic [15:0]   mem_addr,
  input  logic [31:0]   mem_write_data,
  output logic [31:0]   mem_read_data,
  input  logic          load_we,
  input  logic [AW-1:0] load_idx,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] drain_idx,
  output logic [31:0]   drain_data,
  output logic          bad_write
);

  logic [31:0] mem [MEM_WORDS];
  logic [15:0] eng_idx;
  logic        eng_in_range;

  assign eng_idx      = word_index(mem_addr, MSG_BASE);
  assign eng_in_range = (eng_idx < 16'(MEM_WORDS));
  assign bad_write    = mem_we && !eng_in_range;
  assign drain_data   = mem[drain_idx];

  // Contents deliberately survive reset; the host reloads every job.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_idx] <= load_data;
    end
    if (mem_we && eng_in_range) begin
      mem[eng_idx[AW-1:0]] <= mem_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data <= '0;
    end else if (eng_in_range) begin
      mem_read_data <= mem[eng_idx[AW-1:0]];
    end else begin
      mem_read_data <= '0;
    end
  end

endmodule

// File: rtl/sha256_host_bridge.sv
// Host bridge for a SHA-256 engine: loads NUM_OF_WORDS words, pulses start, waits for done, drains 8 hash words.
// One word per cycle in LOAD; hash words are held on out_data/out_valid until out_ready.
module sha256_host_bridge
  import sha256_pkg::*;
#(
  parameter int          NUM_OF_WORDS = 20,
  parameter logic [15:0] MSG_BASE     = 16'h0000,
  parameter int          MEM_WORDS    = 32,
  parameter int          TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_clk,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = $clog2(NUM_OF_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT + WAIT_BUSY_LIMIT + 1);

  bridge_state_t state_q, state_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [2:0]    drain_cnt_q, drain_cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          fsm_err;
  logic          ram_err;
  logic          load_we;
  logic [AW-1:0] load_idx;
  logic [AW-1:0] drain_idx;
  logic          unused_mem_clk;

  // The engine memory port is clocked by clk; mem_clk only exists for pin compatibility.
  assign unused_mem_clk = mem_clk;

  assign message_addr = MSG_BASE;
  assign output_addr  = MSG_BASE + 16'(NUM_OF_WORDS);
  assign busy         = (state_q != LOAD);
  assign load_we      = in_valid && in_ready;
  assign load_idx     = AW'(load_cnt_q);
  assign drain_idx    = AW'(NUM_OF_WORDS) + AW'(drain_cnt_q);

  sha256_word_ram #(
    .MEM_WORDS (MEM_WORDS),
    .MSG_BASE  (MSG_BASE),
    .AW        (AW)
  ) u_ram (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .load_we        (load_we),
    .load_idx       (load_idx),
    .load_data      (in_data),
    .drain_idx      (drain_idx),
    .drain_data     (out_data),
    .bad_write      (ram_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LOAD;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      tmr_q       <= '0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tmr_q       <= tmr_d;
      if (fsm_err || ram_err) begin
        err <= 1'b1;
      end
    end
  end

  // tmr_q counts cycles in the current wait state and is zeroed on every transition.
  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    tmr_d       = tmr_q;
    fsm_err     = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    start       = 1'b0;

    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (load_cnt_q == LW'(NUM_OF_WORDS - 1)) begin
            load_cnt_d = '0;
            state_d    = START;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      START: begin
        start   = 1'b1;
        tmr_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!done) begin
          tmr_d   = '0;
          state_d = WAIT_DONE;
        end else if (tmr_q == TW'(WAIT_BUSY_LIMIT - 1)) begin
          fsm_err = 1'b1;
          tmr_d   = '0;
          state_d = LOAD;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          tmr_d   = '0;
          state_d = DRAIN;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          fsm_err = 1'b1;
          tmr_d   = '0;
          state_d = LOAD;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (drain_cnt_q == 3'(HASH_WORDS - 1)) begin
            drain_cnt_d = '0;
            state_d     = LOAD;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_host_bridge.sv
// Directed bench for sha256_host_bridge with a word-level memory scoreboard checked every cycle.
module tb_sha256_host_bridge;

  localparam int          NUM       = 20;
  localparam logic [15:0] MSG_BASE  = 16'h0000;
  localparam int          MEM_WORDS = 32;
  localparam int          TIMEOUT   = 4096;
  localparam int          WB_LIMIT  = 8;

  logic        clk;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        start;
  logic [15:0] message_addr, output_addr;
  logic        done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        busy, err;

  int total = 0;
  int bad   = 0;

  sha256_host_bridge #(
    .NUM_OF_WORDS (NUM),
    .MSG_BASE     (MSG_BASE),
    .MEM_WORDS    (MEM_WORDS),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .start          (start),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .done           (done),
    .mem_clk        (clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .busy           (busy),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: the memory as the engine and host should see it.
  logic [31:0] model_mem [MEM_WORDS];
  bit          model_known [MEM_WORDS];
  logic [31:0] exp_rd, nxt_rd, prev_data;
  bit          exp_rd_known, nxt_known, prev_stall, prev_err;
  int          drain_k, load_ptr;
  logic [15:0] eidx;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_rd       = '0;
      exp_rd_known = 1'b1;
      drain_k      = 0;
      load_ptr     = 0;
      prev_stall   = 1'b0;
      prev_err     = 1'b0;
    end else begin
      if (exp_rd_known) check("mem_read_data", mem_read_data, exp_rd);
      check("message_addr", {16'h0, message_addr}, 32'(MSG_BASE));
      check("output_addr", {16'h0, output_addr}, 32'(MSG_BASE) + 32'(NUM));
      check("ready_valid_overlap", 32'(in_ready & out_valid), 32'd0);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
      end
      if (out_valid && model_known[NUM + drain_k])
        check("out_data", out_data, model_mem[NUM + drain_k]);
      if (prev_err) check("err_sticky", 32'(err), 32'd1);

      eidx = mem_addr - MSG_BASE;
      if (int'(eidx) < MEM_WORDS) begin
        nxt_rd    = model_mem[eidx[4:0]];
        nxt_known = model_known[eidx[4:0]];
      end else begin
        nxt_rd    = '0;
        nxt_known = 1'b1;
      end
      if (mem_we && int'(eidx) < MEM_WORDS) begin
        model_mem[eidx[4:0]]   = mem_write_data;
        model_known[eidx[4:0]] = 1'b1;
      end
      if (in_valid && in_ready) begin
        model_mem[load_ptr]   = in_data;
        model_known[load_ptr] = 1'b1;
        load_ptr = (load_ptr == NUM - 1) ? 0 : load_ptr + 1;
      end
      if (out_valid && out_ready) drain_k = (drain_k == 7) ? 0 : drain_k + 1;
      prev_stall   = out_valid && !out_ready;
      prev_data    = out_data;
      prev_err     = err;
      exp_rd       = nxt_rd;
      exp_rd_known = nxt_known;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    reset_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Streams NUM words; returns one cycle after the start pulse.
  task automatic load_words(input logic [31:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      in_data = base + 32'(i);
      check("load_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    check("load_done_in_ready", 32'(in_ready), 32'd0);
    check("start_pulse", 32'(start), 32'd1);
    check("busy_after_load", 32'(busy), 32'd1);
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    check("start_single", 32'(start), 32'd0);
  endtask

  task automatic engine_write(input logic [15:0] a, input logic [31:0] d);
    mem_we         = 1'b1;
    mem_addr       = a;
    mem_write_data = d;
    tick();
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic drain_words(input bit toggle, input logic [31:0] base);
    int   got;
    int   cyc;
    logic rdy;
    got = 0;
    cyc = 0;
    rdy = 1'b0;
    while (got < 8 && cyc < 64) begin
      rdy       = toggle ? ~rdy : 1'b1;
      out_ready = rdy;
      if (out_valid && rdy) begin
        check("drain_word", out_data, base + 32'(got));
        got++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_beats", 32'(got), 32'd8);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; done = 1'b1;
    mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err0", 32'(err), 32'd0);
    check("rst_out_valid0", 32'(out_valid), 32'd0);
    check("rst_rdata", mem_read_data, 32'd0);
    check("msg_addr_lit", {16'h0, message_addr}, 32'd0);
    check("out_addr_lit", {16'h0, output_addr}, 32'd20);
    reset_n = 1'b1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Load 0..19, engine reads, writes hash A0..A7, stalled drain.
    load_words(32'd0);
    done = 1'b0;
    mem_addr = 16'd5;
    tick();
    check("rd_addr5", mem_read_data, 32'h5);
    mem_addr = 16'h0040;
    tick();
    check("rd_addr_oor", mem_read_data, 32'h0);
    for (int i = 0; i < 8; i++) engine_write(16'(20 + i), 32'hA0 + 32'(i));
    check("no_err_normal", 32'(err), 32'd0);
    done = 1'b1;
    tick();
    drain_words(1'b1, 32'hA0);

    // Engine never drops done.
    load_words(32'd100);
    check("wb_err_before", 32'(err), 32'd0);
    wait_idle(32, n);
    check("wb_cycles", 32'(n), 32'(WB_LIMIT));
    check("wb_err", 32'(err), 32'd1);
    check("wb_in_ready", 32'(in_ready), 32'd1);
    apply_reset();
    tick();

    // Out-of-range engine write, then read back every word.
    engine_write(16'd40, 32'hDEADBEEF);
    check("oor_err", 32'(err), 32'd1);
    for (int a = 0; a < MEM_WORDS; a++) begin
      mem_addr = 16'(a);
      tick();
      if (a == 8)  check("sweep_w8", mem_read_data, 32'd108);
      if (a == 20) check("sweep_w20", mem_read_data, 32'hA0);
    end
    mem_addr = '0;

    // Reset in the middle of a drain, then a clean job.
    load_words(32'd200);
    done = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) engine_write(16'(20 + i), 32'hB0 + 32'(i));
    done = 1'b1;
    tick();
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    tick();
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_word", out_data, 32'hB3);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_drain_valid", 32'(out_valid), 32'd0);
    check("rst_drain_busy", 32'(busy), 32'd0);
    check("rst_drain_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_drain_ready", 32'(in_ready), 32'd1);
    tick();
    load_words(32'd300);
    done = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) engine_write(16'(20 + i), 32'hC0 + 32'(i));
    done = 1'b1;
    tick();
    drain_words(1'b0, 32'hC0);
    check("fresh_err", 32'(err), 32'd0);

    // Engine starts but never finishes.
    load_words(32'd400);
    done = 1'b0;
    wait_idle(TIMEOUT + 32, n);
    check("timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_in_ready", 32'(in_ready), 32'd1);
    done = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha256_host_bridge.md
SHA256_HOST_BRIDGE -- requirements
Module: sha256_host_bridge

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20: message words loaded per hash.
REQ-002 SHALL have parameter MSG_BASE, default 16'h0000: engine word address of local memory word 0.
REQ-003 SHALL have parameter MEM_WORDS, default 32: local memory depth in 32-bit words, at least NUM_OF_WORDS+8.
REQ-004 SHALL have parameter TIMEOUT, default 4096: maximum cycles spent in WAIT_DONE.
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid, in_ready  in/out  1 each  host message-word handshake.
- in_data  in  32  host message word.
- out_valid, out_ready  out/in  1 each  hash-word handshake.
- out_data  out  32  hash word.
- start  out  1  engine start.
- message_addr, output_addr  out  16 each  engine base addresses.
- done  in  1  engine idle/finished.
- mem_clk  in  1  engine memory clock; ignored, memory runs on clk.
- mem_we  in  1  engine write enable.
- mem_addr  in  16  engine word address.
- mem_write_data  in  32  engine write data.
- mem_read_data  out  32  read data to engine.
- busy  out  1  high in any state other than LOAD.
- err  out  1  sticky error flag.

Function
REQ-006 message_addr SHALL be the constant MSG_BASE; output_addr SHALL be the constant MSG_BASE+NUM_OF_WORDS.
REQ-007 Local memory SHALL be a MEM_WORDS x 32 flop array at index = mem_addr - MSG_BASE (16-bit unsigned); an index >= MEM_WORDS is out of range.
REQ-008 Engine read: mem_read_data SHALL register mem[index] on the clk edge after the address is presented (1-cycle latency); an out-of-range read SHALL return 32'h0.
REQ-009 Engine write: when mem_we=1 and the index is in range, mem[index] SHALL update at the clk edge.
REQ-010 An engine write with an out-of-range index SHALL be discarded and SHALL set err.
REQ-011 FSM states SHALL be LOAD, START, WAIT_BUSY, WAIT_DONE, DRAIN.
REQ-012 LOAD: in_ready=1; each in_valid&in_ready beat SHALL write in_data to mem[load_cnt] and increment load_cnt; the beat with load_cnt=NUM_OF_WORDS-1 SHALL go to START, with load_cnt cleared.
REQ-013 START: start SHALL be high for exactly one cycle, then go to WAIT_BUSY.
REQ-014 WAIT_BUSY: done=0 SHALL go to WAIT_DONE; done still 1 after 8 cycles SHALL set err and return to LOAD.
REQ-015 WAIT_DONE: done=1 SHALL go to DRAIN; TIMEOUT cycles without done SHALL set err and return to LOAD.
REQ-016 DRAIN: out_valid=1 and out_data=mem[NUM_OF_WORDS+drain_cnt] (combinational read); each out_valid&out_ready beat SHALL increment drain_cnt; the beat with drain_cnt=7 SHALL return to LOAD, with drain_cnt cleared.
REQ-017 out_data and out_valid SHALL be held stable while out_valid=1 and out_ready=0.
REQ-018 in_ready SHALL be 0 outside LOAD, and out_valid SHALL be 0 outside DRAIN.
REQ-019 A simultaneous engine write and host load to the same index cannot occur and needs no arbitration; an engine write during LOAD is honoured.
REQ-020 err SHALL be cleared only by reset.

Reset
REQ-021 On reset_n low the block SHALL immediately enter LOAD and drive start=0, in_ready=1 (after release), out_valid=0, busy=0, err=0, mem_read_data=0, load_cnt=0, drain_cnt=0, and clear the timeout counter.
REQ-022 Memory contents SHALL NOT be reset; a reset mid-operation abandons the job, and the host SHALL reload all NUM_OF_WORDS words.

Structure
REQ-023 The FSM state enum and the WAIT_BUSY limit of 8 SHALL live in shared package sha256_pkg, alongside the hash IV constants.
REQ-024 The memory array and engine port SHALL be a sub-module sha256_word_ram; the FSM and handshakes SHALL stay in the top module.

Verification
REQ-025 Load words 0..19 with in_valid held -> in_ready drops after the 20th beat; start is high for exactly 1 cycle on the next cycle.
REQ-026 Engine stub drives mem_addr=5 after the load -> mem_read_data=32'h5 one cycle later; mem_addr=16'h0040 -> 32'h0.
REQ-027 Stub drops done, writes 32'hA0..32'hA7 to addresses 20..27, then raises done; host toggles out_ready every other cycle -> out_data A0..A7 in order, stable while stalled, then in_ready=1.
REQ-028 Stub holds done=1 after start -> err=1 and state LOAD 8 cycles later.
REQ-029 Stub writes mem_addr=40 with mem_we=1 -> err=1, no in-range memory word changes.
REQ-030 Assert reset_n low mid-DRAIN -> out_valid=0 immediately; in_ready=1 after release; a fresh load/hash completes correctly.
